// File: rtl/deserializer_pkg.sv
// Shared types and elaboration helpers for the serial-audio deserializer.
package deserializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Clocks per serial bit; a zero sampling rate yields 0 so the caller's check trips.
    function automatic int unsigned calc_div(input int unsigned sys_freq,
                                             input int unsigned samp_freq);
        if (samp_freq == 0) return 0;
        return sys_freq / samp_freq;
    endfunction

    function automatic bit div_ok(input int unsigned div);
        return div >= 2;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Modulo-DIV bit-period counter: mid-bit sample strobe and end-of-bit strobe.
module bit_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic run_i,
    output logic sample_o,
    output logic bit_end_o
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i || !run_i) begin
            count <= '0;
        end else if (bit_end_o) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign sample_o  = run_i && (count == CW'(DIV / 2));
    assign bit_end_o = run_i && (count == CW'(DIV - 1));

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with valid/ready output and sticky overrun flag.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int unsigned WORD_LENGTH        = 16,
    parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
    parameter int unsigned SAMPLING_FREQUENCY = 1000000
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic                   serial_i,
    input  logic                   ready_i,
    input  logic                   clear_i,
    output logic [WORD_LENGTH-1:0] data_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int unsigned DIV = calc_div(SYSTEM_FREQUENCY, SAMPLING_FREQUENCY);
    localparam int unsigned BCW = $clog2(WORD_LENGTH);

    if (!div_ok(DIV)) begin : g_bad_div
        $error("deserializer: SYSTEM_FREQUENCY/SAMPLING_FREQUENCY must be >= 2");
    end
    if (WORD_LENGTH < 2) begin : g_bad_width
        $error("deserializer: WORD_LENGTH must be >= 2");
    end

    state_t                 state;
    state_t                 state_next;
    logic [BCW-1:0]         bit_cnt;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic [WORD_LENGTH-1:0] shift_next;
    logic [WORD_LENGTH-1:0] word_in;
    logic                   active;
    logic                   sample;
    logic                   bit_end;
    logic                   capture;
    logic                   complete;
    logic                   load;
    logic                   drop;

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .run_i     (active),
        .sample_o  (sample),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_i)  state_next = SHIFT;
            SHIFT:   if (!enable_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign active     = (state == SHIFT) && enable_i;
    assign capture    = active && sample;
    assign complete   = active && bit_end && (bit_cnt == '0);
    assign shift_next = {shift_reg[WORD_LENGTH-2:0], serial_i};
    // With DIV==2 the last sample lands on the completing edge, so include it.
    assign word_in    = capture ? shift_next : shift_reg;
    assign load       = complete && (!valid_o || ready_i);
    assign drop       = complete && valid_o && !ready_i;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            bit_cnt   <= BCW'(WORD_LENGTH - 1);
            shift_reg <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            busy_o <= (state_next == SHIFT);

            if ((state == IDLE) && enable_i) begin
                bit_cnt <= BCW'(WORD_LENGTH - 1);
            end else if (active && bit_end) begin
                bit_cnt <= (bit_cnt == '0) ? BCW'(WORD_LENGTH - 1) : bit_cnt - BCW'(1);
            end

            if (capture) begin
                shift_reg <= shift_next;
            end

            if (load) begin
                data_o  <= word_in;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clear_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench: directed scenarios plus random traffic against a timing-formula model.
module tb_deserializer;

    localparam int unsigned W1 = 8;
    localparam int unsigned D1 = 4;
    localparam int unsigned W2 = 16;
    localparam int unsigned D2 = 100;

    logic clk;
    logic rst_n;
    logic en, ser, rdy, clr;
    logic [W1-1:0] data1;
    logic valid1, busy1, ovr1;
    logic en2, ser2;
    logic [W2-1:0] data2;
    logic valid2, busy2, ovr2;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 0;

    // Reference model state
    bit          m_active;
    int          m_off;
    bit          hist [0:W1*D1];
    logic [W1-1:0] m_data;
    bit          m_valid, m_busy, m_ovr;

    deserializer #(
        .WORD_LENGTH        (W1),
        .SYSTEM_FREQUENCY   (D1),
        .SAMPLING_FREQUENCY (1)
    ) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .enable_i  (en),
        .serial_i  (ser),
        .ready_i   (rdy),
        .clear_i   (clr),
        .data_o    (data1),
        .valid_o   (valid1),
        .busy_o    (busy1),
        .overrun_o (ovr1)
    );

    deserializer dut_default (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .enable_i  (en2),
        .serial_i  (ser2),
        .ready_i   (1'b0),
        .clear_i   (1'b0),
        .data_o    (data2),
        .valid_o   (valid2),
        .busy_o    (busy2),
        .overrun_o (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W1-1:0] w);
        for (int k = 0; k < int'(W1); k++) begin
            ser = w[W1-1-k];
            repeat (D1) tick();
        end
    endtask

    // Model: bit k of a word is the serial value at offset k*DIV + DIV/2 + 1 from t0.
    initial begin
        logic [W1-1:0] word;
        bit complete, set_ovr;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_active = 0; m_off = 0; m_data = '0;
                m_valid = 0; m_busy = 0; m_ovr = 0;
            end else begin
                complete = 0;
                word = '0;
                if (!m_active) begin
                    if (en) begin m_active = 1; m_off = 0; end
                end else if (!en) begin
                    m_active = 0;
                end else begin
                    m_off++;
                    hist[m_off] = ser;
                    if (m_off == int'(W1 * D1)) begin
                        complete = 1;
                        m_off = 0;
                        for (int k = 0; k < int'(W1); k++)
                            word[W1-1-k] = hist[k*D1 + D1/2 + 1];
                    end
                end
                set_ovr = 0;
                if (complete) begin
                    if (!m_valid || rdy) begin m_data = word; m_valid = 1; end
                    else set_ovr = 1;
                end else if (m_valid && rdy) begin
                    m_valid = 0;
                end
                if (set_ovr) m_ovr = 1;
                else if (clr) m_ovr = 0;
                m_busy = m_active;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_data",    32'(data1),  32'(m_data));
            check("cyc_valid",   32'(valid1), 32'(m_valid));
            check("cyc_busy",    32'(busy1),  32'(m_busy));
            check("cyc_overrun", 32'(ovr1),   32'(m_ovr));
        end
    end

    initial begin
        rst_n = 0; en = 0; ser = 0; rdy = 0; clr = 0; en2 = 0; ser2 = 0;
        repeat (3) tick();
        chk_on = 1;
        check("reset_data",  32'(data1),  0);
        check("reset_valid", 32'(valid1), 0);
        check("reset_busy",  32'(busy1),  0);
        rst_n = 1;

        // Single word 0xA5
        en = 1; tick();
        send_word(8'hA5);
        check("a5_valid", 32'(valid1), 1);
        check("a5_data",  32'(data1),  32'h A5);
        check("a5_model", 32'(m_data), 32'h A5);
        check("a5_busy",  32'(busy1),  1);

        // Back-to-back with ready high
        rdy = 1;
        send_word(8'h3C);
        check("b2b_first", 32'(data1), 32'h3C);
        send_word(8'hC3);
        check("b2b_second", 32'(data1), 32'hC3);
        check("b2b_valid",  32'(valid1), 1);
        check("b2b_ovr",    32'(ovr1), 0);

        // Overrun with ready low
        en = 0; tick();
        rdy = 0; en = 1; tick();
        send_word(8'h11);
        send_word(8'h22);
        check("ovr_data", 32'(data1), 32'h11);
        check("ovr_flag", 32'(ovr1), 1);
        check("ovr_model", 32'(m_ovr), 1);
        clr = 1; tick(); clr = 0;
        check("ovr_clear", 32'(ovr1), 0);
        rdy = 1; tick(); rdy = 0;
        check("accept_valid", 32'(valid1), 0);

        // Abort after 5 bits, then a clean word
        en = 0; tick();
        en = 1; tick();
        for (int k = 0; k < 5; k++) begin
            ser = 1'($urandom_range(0, 1));
            repeat (D1) tick();
        end
        en = 0; tick();
        check("abort_busy",  32'(busy1),  0);
        check("abort_valid", 32'(valid1), 0);
        en = 1; tick();
        send_word(8'h5A);
        check("restart_data",  32'(data1),  32'h5A);
        check("restart_valid", 32'(valid1), 1);

        // Reset mid-word while holding a word
        for (int k = 0; k < 3; k++) begin
            ser = 1'($urandom_range(0, 1));
            repeat (D1) tick();
        end
        check("pre_reset_valid", 32'(valid1), 1);
        rst_n = 0; tick();
        check("mid_reset_data",  32'(data1),  0);
        check("mid_reset_valid", 32'(valid1), 0);
        check("mid_reset_busy",  32'(busy1),  0);
        check("mid_reset_ovr",   32'(ovr1),   0);
        rst_n = 1; tick();
        send_word(8'hFF);
        check("post_reset_data", 32'(data1), 32'hFF);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            en    = ($urandom_range(0, 99) < 97);
            ser   = 1'($urandom_range(0, 1));
            rdy   = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 99) < 4);
            rst_n = ($urandom_range(0, 999) >= 2);
            tick();
        end
        rst_n = 1; en = 0; rdy = 0; clr = 0;
        tick();

        // Default configuration: 16 bits, DIV=100, word 0x8001
        begin
            logic [W2-1:0] w2;
            w2 = 16'h8001;
            en2 = 1; tick();
            for (int c = 0; c < int'(W2 * D2); c++) begin
                ser2 = w2[W2-1-c/D2];
                tick();
                if (c == int'(W2 * D2) - 2)
                    check("def_valid_early", 32'(valid2), 0);
            end
            check("def_valid", 32'(valid2), 1);
            check("def_data",  32'(data2),  32'h8001);
            check("def_busy",  32'(busy2),  1);
            check("def_ovr",   32'(ovr2),   0);
        end

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
